// File: rtl/msi_irq_ctrl_pkg.sv
// Shared types and helpers for the MSI interrupt controller: FSM state encoding and
// the host-granted vector folding function.
package msi_irq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_HOLDOFF = 2'd2
   } msi_state_e;

   localparam int MSI_MAX_LOG2 = 5;

   // Sources beyond the host-granted vector count all share the last granted vector.
   function automatic logic [4:0] msi_vec_map(input logic [4:0] idx,
                                              input logic [2:0] width,
                                              input logic       multi);
      logic [2:0] w;
      logic [5:0] span;
      w    = (width > 3'(MSI_MAX_LOG2)) ? 3'(MSI_MAX_LOG2) : width;
      span = 6'd1 << w;
      if (!multi)
         return 5'd0;
      if ({1'b0, idx} < span)
         return idx;
      return 5'(span - 6'd1);
   endfunction

endpackage

// File: rtl/msi_irq_ctrl_if.sv
// Endpoint interrupt handshake towards the PCIe core cfg_interrupt port.
interface msi_irq_ctrl_if;
   logic       intx_msi_request;
   logic       intx_msi_grant;
   logic [4:0] msi_vector_num;

   modport master (output intx_msi_request, output msi_vector_num, input intx_msi_grant);
   modport slave  (input intx_msi_request, input msi_vector_num, output intx_msi_grant);
endinterface

// File: rtl/msi_rr_arb.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module msi_rr_arb #(
   parameter int N_SRC = 8,
   parameter int IDX_W = 3
) (
   input  logic [N_SRC-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             valid,
   output logic [IDX_W-1:0] idx
);
   localparam logic [IDX_W:0] N_L = (IDX_W + 1)'(N_SRC);

   logic [N_SRC-1:0] rot;
   logic [IDX_W:0]   sum;

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      rot   = N_SRC'({req, req} >> ptr);
      valid = 1'b0;
      sum   = '0;
      for (int k = N_SRC - 1; k >= 0; k--) begin
         if (rot[k]) begin
            valid = 1'b1;
            sum   = {1'b0, ptr} + (IDX_W + 1)'(k);
         end
      end
      idx = (sum >= N_L) ? IDX_W'(sum - N_L) : IDX_W'(sum);
   end
endmodule

// File: rtl/msi_irq_ctrl.sv
// MSI interrupt controller: edge capture, masking, round-robin arbitration and vector folding.
// Optional MSI_HOLDOFF_EN adds a post-grant idle window of HOLDOFF_CYCLES.
module msi_irq_ctrl
   import msi_irq_pkg::*;
#(
   parameter int N_SRC            = 8,
   parameter bit MULTI_VECTOR_MSI = 1'b0,
   parameter int CNT_WIDTH        = 16
`ifdef MSI_HOLDOFF_EN
   ,
   parameter int HOLDOFF_CYCLES   = 64
`endif
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_SRC-1:0]     irq_src,
   input  logic [N_SRC-1:0]     irq_mask,
   input  logic                 msi_enable,
   input  logic [2:0]           msi_vector_width,
   msi_irq_ctrl_if.master       msi_if,
   output logic [N_SRC-1:0]     irq_pending,
   output logic [CNT_WIDTH-1:0] msi_sent_cnt
);
   localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   msi_state_e       state_q, state_d;
   logic [N_SRC-1:0] src_q, mask_q, src_rise, eligible, grant_clr;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_nxt, win_idx_q, arb_idx;
   logic [4:0]       vec_q;
   logic             arb_valid, grant_fire, load_req;

   assign src_rise   = irq_src & ~src_q;
   assign eligible   = irq_pending & ~mask_q;
   assign grant_fire = (state_q == ST_REQ) && msi_if.intx_msi_grant;
   assign grant_clr  = grant_fire ? (N_SRC'(1) << win_idx_q) : '0;
   assign rr_ptr_nxt = (win_idx_q == IDX_W'(N_SRC - 1)) ? '0 : win_idx_q + IDX_W'(1);

   assign msi_if.intx_msi_request = (state_q == ST_REQ);
   assign msi_if.msi_vector_num   = vec_q;

   msi_rr_arb #(.N_SRC(N_SRC), .IDX_W(IDX_W)) u_arb (
      .req   (eligible),
      .ptr   (rr_ptr_q),
      .valid (arb_valid),
      .idx   (arb_idx)
   );

`ifdef MSI_HOLDOFF_EN
   localparam int HO_W = $clog2(HOLDOFF_CYCLES + 1);
   logic [HO_W-1:0] holdoff_q;

   // Loaded with HOLDOFF_CYCLES-1 so the FSM spends exactly HOLDOFF_CYCLES cycles in HOLDOFF.
   always_ff @(posedge clk) begin
      if (!rst_n)
         holdoff_q <= '0;
      else if (grant_fire)
         holdoff_q <= HO_W'(HOLDOFF_CYCLES - 1);
      else if (state_q == ST_HOLDOFF && holdoff_q != '0)
         holdoff_q <= holdoff_q - HO_W'(1);
   end
`endif

   always_comb begin
      state_d  = state_q;
      load_req = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (msi_enable && arb_valid) begin
               state_d  = ST_REQ;
               load_req = 1'b1;
            end
         end
         ST_REQ: begin
            if (msi_if.intx_msi_grant) begin
`ifdef MSI_HOLDOFF_EN
               state_d = ST_HOLDOFF;
`else
               state_d = ST_IDLE;
`endif
            end
         end
`ifdef MSI_HOLDOFF_EN
         ST_HOLDOFF: begin
            if (holdoff_q == '0)
               state_d = ST_IDLE;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         src_q        <= '0;
         mask_q       <= '0;
         irq_pending  <= '0;
         rr_ptr_q     <= '0;
         win_idx_q    <= '0;
         vec_q        <= '0;
         msi_sent_cnt <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= irq_src;
         mask_q  <= irq_mask;
         // A fresh edge on the granted source overrides its clear.
         irq_pending <= (irq_pending & ~grant_clr) | src_rise;
         if (load_req) begin
            win_idx_q <= arb_idx;
            vec_q     <= msi_vec_map(5'(arb_idx), msi_vector_width, MULTI_VECTOR_MSI);
         end
         if (grant_fire) begin
            msi_sent_cnt <= msi_sent_cnt + CNT_WIDTH'(1);
            rr_ptr_q     <= rr_ptr_nxt;
         end
      end
   end
endmodule
